alu_issue_stage: RTL

- Upstream feeder for the 8-bit ALU: accepts one two-operand instruction per valid/ready handshake and reads operands from an internal register file.
- Drives the ALU's operand1, operand2, operation and enable inputs, captures its 8-bit result, and writes the result back to the register file.
- Handles load-immediate (opcode 3'b111, which the ALU does not implement) and divide-by-zero locally.
- Sits between instruction decode and the ALU in the CPU datapath.

---
 rtl/alu_issue_stage_pkg.sv | 22 ++
 rtl/alu_issue_stage_regfile_2r1w.sv | 44 ++++
 rtl/alu_issue_stage.sv | 118 +++++++++++
 3 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, FSM states and default sizes.
package alu_issue_stage_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_NUM_REGS = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_LDI = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

endpackage

// File: rtl/alu_issue_stage_regfile_2r1w.sv
// Register file with two captured read ports, one write port and a combinational debug port.
module regfile_2r1w #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  ra1,
    input  logic [IDX_W-1:0]  ra2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              we,
    input  logic [IDX_W-1:0]  wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [IDX_W-1:0]  dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    // Read ports only update on rd_en, so the captured operands hold between accepts.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
            rdata1 <= '0;
            rdata2 <= '0;
        end else begin
            if (we) begin
                mem[wa] <= wd;
            end
            if (rd_en) begin
                rdata1 <= mem[ra1];
                rdata2 <= mem[ra2];
            end
        end
    end

    assign dbg_data = mem[dbg_sel];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage feeding the 8-bit ALU: operand fetch, one-cycle execute, register write-back.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int                 DATA_W     = DEF_DATA_W,
    parameter int                 NUM_REGS   = DEF_NUM_REGS,
    parameter logic [DATA_W-1:0]  DIV0_VALUE = 8'hFF,
    localparam int                IDX_W      = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [IDX_W-1:0]  in_rd,
    input  logic [IDX_W-1:0]  in_rs,
    input  logic [DATA_W-1:0] in_imm,
    output logic [DATA_W-1:0] alu_operand1,
    output logic [DATA_W-1:0] alu_operand2,
    output logic [2:0]        alu_operation,
    output logic              alu_enable,
    input  logic [DATA_W-1:0] alu_result,
    output logic              wb_valid,
    output logic [IDX_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              flag_zero,
    output logic              flag_div0,
    input  logic [IDX_W-1:0]  dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    state_t            state;
    logic [IDX_W-1:0]  rd_q;
    logic [DATA_W-1:0] imm_q;
    logic              div0_q;
    logic              accept;
    logic              is_div0;
    logic [DATA_W-1:0] exec_result;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    // alu_operation holds the latched opcode, so divide-by-zero is judged on the captured operand.
    assign is_div0    = (alu_operation == OP_DIV) && (alu_operand2 == '0);
    assign alu_enable = (state == EXEC) && (alu_operation != OP_LDI) && !is_div0;

    always_comb begin
        exec_result = alu_result;
        if (alu_operation == OP_LDI) begin
            exec_result = imm_q;
        end else if (is_div0) begin
            exec_result = DIV0_VALUE;
        end
    end

    regfile_2r1w #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .rd_en    (accept),
        .ra1      (in_rd),
        .ra2      (in_rs),
        .rdata1   (alu_operand1),
        .rdata2   (alu_operand2),
        .we       (state == WB),
        .wa       (wb_rd),
        .wd       (wb_data),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            alu_operation <= '0;
            rd_q          <= '0;
            imm_q         <= '0;
            div0_q        <= 1'b0;
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
            flag_zero     <= 1'b0;
            flag_div0     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_operation <= in_op;
                        rd_q          <= in_rd;
                        imm_q         <= in_imm;
                        state         <= EXEC;
                    end
                end
                EXEC: begin
                    wb_valid <= 1'b1;
                    wb_rd    <= rd_q;
                    wb_data  <= exec_result;
                    div0_q   <= is_div0;
                    state    <= WB;
                end
                WB: begin
                    wb_valid  <= 1'b0;
                    flag_zero <= (wb_data == '0);
                    flag_div0 <= div0_q;
                    state     <= IDLE;
                end
                default: begin
                    wb_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
